// File: rtl/reaction_pkg.sv
// reaction_pkg: shared encodings for the reaction timer.
//   - game_state_e : encoding of the upstream game-state bus
//   - rt_state_e   : internal reaction FSM states
//   - BCD_MAX      : saturated / "no result yet" BCD value
//   - int_to_bcd   : elaboration-time helper to express integer parameters in BCD
package reaction_pkg;

  typedef enum logic [1:0] {
    GS_IDLE      = 2'd0,
    GS_LOAD      = 2'd1,
    GS_COUNTDOWN = 2'd2,
    GS_MEASURE   = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_TIMING = 2'd2,
    ST_HOLD   = 2'd3
  } rt_state_e;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Converts a constant integer (0..9999) to 4 BCD digits; only used on parameters.
  function automatic logic [15:0] int_to_bcd(input int unsigned value);
    logic [15:0] bcd;
    int unsigned rem;
    bcd = 16'h0000;
    rem = value;
    for (int i = 0; i < 4; i++) begin
      bcd[i*4 +: 4] = 4'(rem % 32'd10);
      rem = rem / 32'd10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// reaction_timer_if: game-side signals of the reaction timer.
//   Inputs to the timer : state[1:0], done, button (raw, asynchronous)
//   Outputs of the timer: react_bcd[15:0], best_bcd[15:0], result_valid, early, measuring
//   master modport: the game controller / bench; slave modport: the timer.
interface reaction_timer_if;
  logic [1:0]  state;
  logic        done;
  logic        button;
  logic [15:0] react_bcd;
  logic [15:0] best_bcd;
  logic        result_valid;
  logic        early;
  logic        measuring;

  modport master (
    output state, done, button,
    input  react_bcd, best_bcd, result_valid, early, measuring
  );

  modport slave (
    input  state, done, button,
    output react_bcd, best_bcd, result_valid, early, measuring
  );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, counter debouncer and rising-edge detector.
//   clock, reset_n : system clock, asynchronous active-low reset
//   button         : raw asynchronous button
//   press          : registered one-clock pulse on the debounced 0->1 edge
//                    (raw-to-press latency is 2 + DEBOUNCE_MS clocks)
module button_debounce #(
  parameter int DEBOUNCE_MS = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic press
);
  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;
  logic          differ_s;
  logic          flip_s;

  // The level flips on the DEBOUNCE_MS-th consecutive clock of disagreement.
  assign differ_s = sync2_r ^ level_r;
  assign flip_s   = differ_s && (cnt_r == CNT_LAST);
  assign press    = press_r;

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter, debounced level and press pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      press_r <= flip_s & sync2_r;
      if (!differ_s) begin
        cnt_r <= '0;
      end else if (flip_s) begin
        cnt_r   <= '0;
        level_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end
endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: measures player reaction time in ms (clocks) as 4-digit BCD.
//   clock, reset_n : 1 kHz clock, asynchronous active-low reset
//   io (slave)     : state/done/button in; react_bcd, best_bcd, result_valid,
//                    early, measuring out (all registered)
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int DEBOUNCE_MS = 4,
  parameter int MAX_COUNT   = 9999
) (
  input  logic clock,
  input  logic reset_n,
  reaction_timer_if.slave io
);
  localparam logic [15:0] COUNT_LIMIT = int_to_bcd(MAX_COUNT);

  rt_state_e   fsm_r, fsm_nxt_s;
  logic [15:0] count_r, count_nxt_s, count_inc_s;
  logic [15:0] react_r, react_nxt_s;
  logic [15:0] best_r, best_nxt_s;
  logic        rv_r, rv_nxt_s;
  logic        early_r, early_nxt_s;
  logic        meas_r;
  logic        press_s;

  button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .button  (io.button),
    .press   (press_s)
  );

  // BCD +1 with decimal carry ripple across the four digits.
  always_comb begin : bcd_inc
    logic carry_v;
    carry_v     = 1'b1;
    count_inc_s = count_r;
    for (int i = 0; i < 4; i++) begin
      if (carry_v) begin
        if (count_r[i*4 +: 4] == 4'd9) begin
          count_inc_s[i*4 +: 4] = 4'd0;
        end else begin
          count_inc_s[i*4 +: 4] = count_r[i*4 +: 4] + 4'd1;
          carry_v = 1'b0;
        end
      end else begin
        count_inc_s[i*4 +: 4] = count_r[i*4 +: 4];
      end
    end
  end

  // Next-state and next-output logic of the reaction FSM.
  always_comb begin
    fsm_nxt_s   = fsm_r;
    count_nxt_s = count_r;
    react_nxt_s = react_r;
    best_nxt_s  = best_r;
    rv_nxt_s    = 1'b0;
    early_nxt_s = early_r;
    if (io.state == GS_IDLE) begin
      fsm_nxt_s = ST_IDLE;
    end else begin
      case (fsm_r)
        ST_IDLE, ST_HOLD: begin
          if (io.state == GS_LOAD) begin
            fsm_nxt_s   = ST_ARMED;
            early_nxt_s = 1'b0;
          end else begin
            fsm_nxt_s = fsm_r;
          end
        end
        ST_ARMED: begin
          // A press wins over done, so a same-cycle press is still early.
          if (press_s) begin
            fsm_nxt_s   = ST_HOLD;
            early_nxt_s = 1'b1;
          end else if (io.done) begin
            fsm_nxt_s   = ST_TIMING;
            count_nxt_s = 16'h0001;
          end else begin
            fsm_nxt_s = ST_ARMED;
          end
        end
        ST_TIMING: begin
          if (press_s) begin
            fsm_nxt_s   = ST_HOLD;
            react_nxt_s = count_r;
            rv_nxt_s    = 1'b1;
            // BCD digits order the same way as binary, so a plain compare works.
            if (count_r < best_r) begin
              best_nxt_s = count_r;
            end else begin
              best_nxt_s = best_r;
            end
          end else if (count_r >= COUNT_LIMIT) begin
            fsm_nxt_s   = ST_HOLD;
            react_nxt_s = BCD_MAX;
            rv_nxt_s    = 1'b1;
          end else begin
            count_nxt_s = count_inc_s;
          end
        end
        default: begin
          fsm_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_r   <= ST_IDLE;
      count_r <= 16'h0000;
      react_r <= 16'h0000;
      best_r  <= BCD_MAX;
      rv_r    <= 1'b0;
      early_r <= 1'b0;
      meas_r  <= 1'b0;
    end else begin
      fsm_r   <= fsm_nxt_s;
      count_r <= count_nxt_s;
      react_r <= react_nxt_s;
      best_r  <= best_nxt_s;
      rv_r    <= rv_nxt_s;
      early_r <= early_nxt_s;
      meas_r  <= (fsm_nxt_s == ST_TIMING);
    end
  end

  assign io.react_bcd    = react_r;
  assign io.best_bcd     = best_r;
  assign io.result_valid = rv_r;
  assign io.early        = early_r;
  assign io.measuring    = meas_r;
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed-vector bench for reaction_timer (DEBOUNCE_MS=4, MAX_COUNT=9999).
module tb_reaction_timer;
  import reaction_pkg::*;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  reaction_timer_if io ();

  reaction_timer #(.DEBOUNCE_MS(4), .MAX_COUNT(9999)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full game round ending with a press at TIMING count c.
  // After the entry edge the count is 1; after k more edges it is k+1.
  // Press becomes visible 6 edges after the raw button rises.
  task automatic do_round(input int c, input logic [15:0] exp_react, input logic [15:0] exp_best);
    io.state = GS_LOAD;
    step();
    io.state = GS_COUNTDOWN;
    io.done  = 1'b1;
    step();
    io.state = GS_MEASURE;
    io.done  = 1'b0;
    repeat (c - 7) step();
    io.button = 1'b1;
    repeat (6) step();
    check_eq("round_measuring", 16'(io.measuring), 16'h0001);
    check_eq("round_rv_before", 16'(io.result_valid), 16'h0000);
    step();
    check_eq("round_react", io.react_bcd, exp_react);
    check_eq("round_best", io.best_bcd, exp_best);
    check_eq("round_rv_pulse", 16'(io.result_valid), 16'h0001);
    check_eq("round_meas_off", 16'(io.measuring), 16'h0000);
    io.button = 1'b0;
    step();
    check_eq("round_rv_single", 16'(io.result_valid), 16'h0000);
    repeat (8) step();
  endtask

  int          tgt   [5] = '{250, 300, 120, 100, 10};
  logic [15:0] exp_r [5] = '{16'h0250, 16'h0300, 16'h0120, 16'h0100, 16'h0010};
  logic [15:0] exp_b [5] = '{16'h0250, 16'h0250, 16'h0120, 16'h0100, 16'h0010};

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    io.state  = GS_IDLE;
    io.done   = 1'b0;
    io.button = 1'b0;
    repeat (3) step();
    check_eq("rst_react", io.react_bcd, 16'h0000);
    check_eq("rst_best", io.best_bcd, 16'h9999);
    check_eq("rst_rv", 16'(io.result_valid), 16'h0000);
    check_eq("rst_early", 16'(io.early), 16'h0000);
    check_eq("rst_meas", 16'(io.measuring), 16'h0000);
    reset_n = 1'b1;
    step();

    // Glitch rejection and press latency, observed through an early press.
    io.state = GS_LOAD;
    step();
    io.state = GS_COUNTDOWN;
    io.button = 1'b1;
    repeat (3) step();
    io.button = 1'b0;
    repeat (10) step();
    check_eq("glitch_no_press", 16'(io.early), 16'h0000);
    io.button = 1'b1;
    repeat (4) step();
    io.button = 1'b0;
    repeat (2) step();
    check_eq("press_lat_not_yet", 16'(io.early), 16'h0000);
    step();
    check_eq("early_set", 16'(io.early), 16'h0001);
    check_eq("early_no_rv", 16'(io.result_valid), 16'h0000);
    check_eq("early_react", io.react_bcd, 16'h0000);
    check_eq("early_best", io.best_bcd, 16'h9999);
    check_eq("early_meas", 16'(io.measuring), 16'h0000);
    repeat (8) step();
    check_eq("early_sticky", 16'(io.early), 16'h0001);

    // Rounds: first sets best, slower keeps it, faster ones replace it (carries 0009/0099).
    for (int i = 0; i < 5; i++) begin
      do_round(tgt[i], exp_r[i], exp_b[i]);
    end

    // Press and done in the same ARMED cycle counts as early.
    io.state = GS_LOAD;
    step();
    io.state  = GS_COUNTDOWN;
    io.button = 1'b1;
    repeat (6) step();
    io.done = 1'b1;
    step();
    check_eq("tie_early", 16'(io.early), 16'h0001);
    check_eq("tie_meas", 16'(io.measuring), 16'h0000);
    check_eq("tie_rv", 16'(io.result_valid), 16'h0000);
    check_eq("tie_react", io.react_bcd, 16'h0010);
    check_eq("tie_best", io.best_bcd, 16'h0010);
    io.button = 1'b0;
    io.done   = 1'b0;
    repeat (8) step();

    // Early is held in IDLE and cleared on IDLE->ARMED.
    io.state = GS_IDLE;
    step();
    check_eq("idle_early_held", 16'(io.early), 16'h0001);
    io.state = GS_LOAD;
    step();
    check_eq("arm_early_clr", 16'(io.early), 16'h0000);

    // Timeout: no press for 9999 TIMING cycles.
    io.state = GS_COUNTDOWN;
    io.done  = 1'b1;
    step();
    io.state = GS_MEASURE;
    io.done  = 1'b0;
    repeat (9998) step();
    check_eq("to_rv_before", 16'(io.result_valid), 16'h0000);
    check_eq("to_meas_before", 16'(io.measuring), 16'h0001);
    step();
    check_eq("to_react", io.react_bcd, 16'h9999);
    check_eq("to_rv", 16'(io.result_valid), 16'h0001);
    check_eq("to_best", io.best_bcd, 16'h0010);
    step();
    check_eq("to_rv_single", 16'(io.result_valid), 16'h0000);
    check_eq("to_no_wrap", io.react_bcd, 16'h9999);
    check_eq("to_meas_off", 16'(io.measuring), 16'h0000);

    // state==0 forces IDLE out of TIMING, results held.
    io.state = GS_LOAD;
    step();
    io.state = GS_COUNTDOWN;
    io.done  = 1'b1;
    step();
    io.done = 1'b0;
    repeat (5) step();
    check_eq("abort_meas_on", 16'(io.measuring), 16'h0001);
    io.state = GS_IDLE;
    step();
    check_eq("abort_meas_off", 16'(io.measuring), 16'h0000);
    check_eq("abort_react", io.react_bcd, 16'h9999);
    check_eq("abort_best", io.best_bcd, 16'h0010);

    // Reset in the middle of a measurement at count 0500.
    io.state = GS_LOAD;
    step();
    io.state = GS_COUNTDOWN;
    io.done  = 1'b1;
    step();
    io.state = GS_MEASURE;
    io.done  = 1'b0;
    repeat (499) step();
    check_eq("mid_meas", 16'(io.measuring), 16'h0001);
    reset_n = 1'b0;
    #1;
    check_eq("mrst_react", io.react_bcd, 16'h0000);
    check_eq("mrst_best", io.best_bcd, 16'h9999);
    check_eq("mrst_rv", 16'(io.result_valid), 16'h0000);
    check_eq("mrst_early", 16'(io.early), 16'h0000);
    check_eq("mrst_meas", 16'(io.measuring), 16'h0000);
    repeat (2) step();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check_eq("post_rst_rv", 16'(io.result_valid), 16'h0000);
    end
    check_eq("post_rst_react", io.react_bcd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
